cdb_broadcaster: RTL and testbench

//  Producer end of the common data bus: collects completed results from NUM_SRC sources
//   (adder RS, load unit, store unit), buffers one result per source and arbitrates round-robin.

---
 rtl/cdb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/cdb_broadcaster.sv | 110 +++++++++++
 tb/tb_cdb_broadcaster.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared types and constants for the common data bus broadcaster.
package cdb_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_REG_W  = 3;
    localparam int DEF_OP_W   = 4;

    localparam logic [DEF_OP_W-1:0] OP_ADD = 4'b0000;
    localparam logic [DEF_OP_W-1:0] OP_SUB = 4'b0001;
    localparam logic [DEF_OP_W-1:0] OP_LD  = 4'b0010;
    localparam logic [DEF_OP_W-1:0] OP_SD  = 4'b0011;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_REG_W-1:0]  dest;
        logic [DEF_OP_W-1:0]   op;
    } cdb_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requesting index at or after ptr, wrapping N-1 -> 0.
module rr_arbiter
    import cdb_pkg::*;
#(
    parameter int N = 3,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] grantIdx,
    output logic         anyGrant
);

    always_comb begin
        int idx;
        idx      = 0;
        grant    = '0;
        grantIdx = '0;
        anyGrant = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!anyGrant && req[idx]) begin
                anyGrant    = 1'b1;
                grant[idx]  = 1'b1;
                grantIdx    = idx[W-1:0];
            end
        end
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// CDB producer: one holding buffer per source, round-robin grant, one broadcast per cycle.
// Optional statistics counters are enabled with the CDB_STATS_EN macro.
module cdb_broadcaster
    import cdb_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_W   = DEF_REG_W,
    parameter int OP_W    = DEF_OP_W,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic                      clock,
    input  logic                      Reset,
    input  logic [NUM_SRC-1:0]        req_valid,
    input  logic [NUM_SRC*DATA_W-1:0] req_data,
    input  logic [NUM_SRC*REG_W-1:0]  req_dest,
    input  logic [NUM_SRC*OP_W-1:0]   req_op,
    output logic [NUM_SRC-1:0]        req_ready,
    input  logic                      cdb_hold,
    output logic                      cdb_valid,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [REG_W-1:0]          cdb_dest,
    output logic [OP_W-1:0]           cdb_op,
    output logic [SRC_W-1:0]          cdb_src
`ifdef CDB_STATS_EN
    ,
    output logic [15:0]               bcast_count,
    output logic [15:0]               hold_count
`endif
);

    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] grant;
    logic [DATA_W-1:0]  bufData [NUM_SRC];
    logic [REG_W-1:0]   bufDest [NUM_SRC];
    logic [OP_W-1:0]    bufOp   [NUM_SRC];
    logic [SRC_W-1:0]   ptr;
    logic [SRC_W-1:0]   winner;
    logic               anyEligible;
    logic               doGrant;

    assign req_ready = ~full;
    assign doGrant   = anyEligible && !cdb_hold;

    // Arbitrating on the registered full vector keeps same-edge captures out of the race.
    rr_arbiter #(.N(NUM_SRC), .W(SRC_W)) arb (
        .req      (full),
        .ptr      (ptr),
        .grant    (grant),
        .grantIdx (winner),
        .anyGrant (anyEligible)
    );

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            full <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                bufData[i] <= '0;
                bufDest[i] <= '0;
                bufOp[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (doGrant && grant[i]) begin
                    full[i] <= 1'b0;
                end else if (req_valid[i] && !full[i]) begin
                    full[i]    <= 1'b1;
                    bufData[i] <= req_data[i*DATA_W +: DATA_W];
                    bufDest[i] <= req_dest[i*REG_W +: REG_W];
                    bufOp[i]   <= req_op[i*OP_W +: OP_W];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            cdb_valid <= 1'b0;
            cdb_data  <= '0;
            cdb_dest  <= '0;
            cdb_op    <= '0;
            cdb_src   <= '0;
            ptr       <= '0;
        end else if (!cdb_hold) begin
            if (anyEligible) begin
                cdb_valid <= 1'b1;
                cdb_data  <= bufData[winner];
                cdb_dest  <= bufDest[winner];
                cdb_op    <= bufOp[winner];
                cdb_src   <= winner;
                ptr       <= (winner == SRC_W'(NUM_SRC - 1)) ? '0 : winner + SRC_W'(1);
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

`ifdef CDB_STATS_EN
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            bcast_count <= '0;
            hold_count  <= '0;
        end else begin
            if (doGrant && bcast_count != 16'hFFFF) bcast_count <= bcast_count + 16'd1;
            if (cdb_hold && |full && hold_count != 16'hFFFF) hold_count <= hold_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed self-checking bench for cdb_broadcaster (default build; stats checks under CDB_STATS_EN).
module tb_cdb_broadcaster;
    import cdb_pkg::*;

    logic        clock;
    logic        Reset;
    logic [2:0]  req_valid;
    logic [47:0] req_data;
    logic [8:0]  req_dest;
    logic [11:0] req_op;
    logic [2:0]  req_ready;
    logic        cdb_hold;
    logic        cdb_valid;
    logic [15:0] cdb_data;
    logic [2:0]  cdb_dest;
    logic [3:0]  cdb_op;
    logic [1:0]  cdb_src;
`ifdef CDB_STATS_EN
    logic [15:0] bcast_count;
    logic [15:0] hold_count;
`endif

    int assertCount = 0;
    int failCount   = 0;

    cdb_broadcaster dut (
        .clock     (clock),
        .Reset     (Reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_dest  (req_dest),
        .req_op    (req_op),
        .req_ready (req_ready),
        .cdb_hold  (cdb_hold),
        .cdb_valid (cdb_valid),
        .cdb_data  (cdb_data),
        .cdb_dest  (cdb_dest),
        .cdb_op    (cdb_op),
        .cdb_src   (cdb_src)
`ifdef CDB_STATS_EN
        ,
        .bcast_count (bcast_count),
        .hold_count  (hold_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] v,
                                 input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                                 input logic [2:0] r0, input logic [2:0] r1, input logic [2:0] r2,
                                 input logic [3:0] o0, input logic [3:0] o1, input logic [3:0] o2);
        req_valid = v;
        req_data  = {d2, d1, d0};
        req_dest  = {r2, r1, r0};
        req_op    = {o2, o1, o0};
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkBcast(input string tag, input logic [15:0] d, input logic [2:0] r,
                              input logic [3:0] o, input logic [1:0] s);
        checkOutput({tag, ".valid"}, 32'(cdb_valid), 32'd1);
        checkOutput({tag, ".data"},  32'(cdb_data),  32'(d));
        checkOutput({tag, ".dest"},  32'(cdb_dest),  32'(r));
        checkOutput({tag, ".op"},    32'(cdb_op),    32'(o));
        checkOutput({tag, ".src"},   32'(cdb_src),   32'(s));
    endtask

    initial begin
        logic [1:0] fairSeq [8];
        fairSeq = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0};

        Reset    = 1'b0;
        cdb_hold = 1'b0;
        applyStimulus(3'b000, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, OP_ADD, OP_ADD, OP_ADD);
        #3;
        checkOutput("rst.valid", 32'(cdb_valid), 32'd0);
        checkOutput("rst.ready", 32'(req_ready), 32'b111);
        checkOutput("rst.data",  32'(cdb_data),  32'd0);
        checkOutput("rst.src",   32'(cdb_src),   32'd0);
        Reset = 1'b1;

        // Contention: all three buffers full with ptr at 0
        applyStimulus(3'b111, 16'h1110, 16'h2220, 16'h3330, 3'd1, 3'd2, 3'd3, OP_ADD, OP_SUB, OP_LD);
        step();
        applyStimulus(3'b000, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, OP_ADD, OP_ADD, OP_ADD);
        checkOutput("cont.ready0", 32'(req_ready), 32'b000);
        checkOutput("cont.idle",   32'(cdb_valid), 32'd0);
        step();
        checkBcast("cont.g0", 16'h1110, 3'd1, OP_ADD, 2'd0);
        checkOutput("cont.ready1", 32'(req_ready), 32'b001);
        step();
        checkBcast("cont.g1", 16'h2220, 3'd2, OP_SUB, 2'd1);
        checkOutput("cont.ready2", 32'(req_ready), 32'b011);
        step();
        checkBcast("cont.g2", 16'h3330, 3'd3, OP_LD, 2'd2);
        checkOutput("cont.ready3", 32'(req_ready), 32'b111);
        step();
        checkOutput("cont.done.valid", 32'(cdb_valid), 32'd0);
        checkOutput("cont.done.data",  32'(cdb_data),  32'h3330);

        // Hold during a broadcast; ptr back at 0 so src0 wins first
        applyStimulus(3'b111, 16'h0A01, 16'h0A02, 16'h0A03, 3'd5, 3'd6, 3'd7, OP_SUB, OP_ADD, OP_LD);
        step();
        applyStimulus(3'b000, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, OP_ADD, OP_ADD, OP_ADD);
        step();
        checkBcast("hold.pre", 16'h0A01, 3'd5, OP_SUB, 2'd0);
        cdb_hold = 1'b1;
        applyStimulus(3'b001, 16'h0B01, 16'h0, 16'h0, 3'd4, 3'd0, 3'd0, OP_SD, OP_ADD, OP_ADD);
        step();
        applyStimulus(3'b000, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, OP_ADD, OP_ADD, OP_ADD);
        checkBcast("hold.h1", 16'h0A01, 3'd5, OP_SUB, 2'd0);
        checkOutput("hold.capture", 32'(req_ready), 32'b000);
        for (int c = 2; c <= 4; c++) begin
            step();
            checkBcast($sformatf("hold.h%0d", c), 16'h0A01, 3'd5, OP_SUB, 2'd0);
        end
        cdb_hold = 1'b0;
        step();
        checkBcast("hold.r1", 16'h0A02, 3'd6, OP_ADD, 2'd1);
        step();
        checkBcast("hold.r2", 16'h0A03, 3'd7, OP_LD, 2'd2);
        step();
        checkBcast("hold.r3", 16'h0B01, 3'd4, OP_SD, 2'd0);
        step();
        checkOutput("hold.done", 32'(cdb_valid), 32'd0);

        // Single source: one-cycle buffering, ready low for exactly one cycle
        applyStimulus(3'b010, 16'h0, 16'h0042, 16'h0, 3'd0, 3'd3, 3'd0, OP_ADD, OP_ADD, OP_ADD);
        step();
        applyStimulus(3'b000, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, OP_ADD, OP_ADD, OP_ADD);
        checkOutput("single.ready.low", 32'(req_ready), 32'b101);
        checkOutput("single.notyet",    32'(cdb_valid), 32'd0);
        step();
        checkBcast("single.bcast", 16'h0042, 3'd3, OP_ADD, 2'd1);
        checkOutput("single.ready.back", 32'(req_ready), 32'b111);
        step();
        checkOutput("single.pulse", 32'(cdb_valid), 32'd0);

        // Fairness: src0 and src2 offer every cycle; ptr starts at 2
        applyStimulus(3'b101, 16'h00C0, 16'h0, 16'h00C2, 3'd1, 3'd0, 3'd2, OP_ADD, OP_ADD, OP_SUB);
        step();
        checkOutput("fair.first.idle", 32'(cdb_valid), 32'd0);
        for (int c = 0; c < 6; c++) begin
            step();
            checkOutput($sformatf("fair.valid%0d", c), 32'(cdb_valid), 32'd1);
            checkOutput($sformatf("fair.src%0d", c),   32'(cdb_src),   32'(fairSeq[c]));
        end
        applyStimulus(3'b000, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, OP_ADD, OP_ADD, OP_ADD);
        step();
        checkBcast("fair.drain", 16'h00C2, 3'd2, OP_SUB, 2'd2);
        step();
        checkOutput("fair.empty", 32'(cdb_valid), 32'd0);

`ifdef CDB_STATS_EN
        checkOutput("stats.bcast", 32'(bcast_count), 32'd15);
        checkOutput("stats.hold",  32'(hold_count),  32'd4);
`endif

        // Mid-run reset with an in-flight broadcast and two buffers still full
        applyStimulus(3'b111, 16'hD000, 16'hD001, 16'hD002, 3'd1, 3'd1, 3'd1, OP_ADD, OP_ADD, OP_ADD);
        step();
        applyStimulus(3'b000, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0, OP_ADD, OP_ADD, OP_ADD);
        step();
        checkOutput("mrst.inflight", 32'(cdb_valid), 32'd1);
        checkOutput("mrst.twofull",  32'(req_ready), 32'b001);
        #2 Reset = 1'b0;
        #1;
        checkOutput("mrst.valid", 32'(cdb_valid), 32'd0);
        checkOutput("mrst.ready", 32'(req_ready), 32'b111);
        checkOutput("mrst.data",  32'(cdb_data),  32'd0);
        checkOutput("mrst.dest",  32'(cdb_dest),  32'd0);
        checkOutput("mrst.src",   32'(cdb_src),   32'd0);
`ifdef CDB_STATS_EN
        checkOutput("mrst.bcast", 32'(bcast_count), 32'd0);
`endif
        #1 Reset = 1'b1;
        step();
        checkOutput("mrst.lost1", 32'(cdb_valid), 32'd0);
        step();
        checkOutput("mrst.lost2", 32'(cdb_valid), 32'd0);
        checkOutput("mrst.ready2", 32'(req_ready), 32'b111);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
